snake_input_ctrl: RTL and testbench

Conditions the raw board inputs for the snake game core, directly upstream of `Snake_Game`. It synchronises and debounces four active-low direction buttons and one pause button. It queues one direction request, rejecting 180° reversals, and commits that request on the game-step strobe. It drives the core's `i_Push` and `i_Pause` inputs with clean, registered levels.

---
 rtl/snake_input_ctrl.sv | 176 +++++++++++++++++
 tb/tb_snake_input_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: synchronises and debounces the raw snake-game buttons, queues
// one direction request with 180-degree reversal rejection, commits it on the game
// step strobe, and produces a toggled pause level. All outputs are registered.
module snake_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] i_Push_Raw,
    input  logic       i_Pause_Raw,
    input  logic       i_Tick,
    output logic [3:0] o_Push,
    output logic       o_Pause,
    output logic       o_Valid
);

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam int NUM_IN = 5;

    // Inputs are converted to active-high "pressed" before synchronising so that a
    // cleared register always means released. Bit 4 is pause, bits 3:0 directions.
    logic [NUM_IN-1:0] raw_act;
    assign raw_act = {i_Pause_Raw, ~i_Push_Raw};

    logic [NUM_IN-1:0] sync1_q;
    logic [NUM_IN-1:0] sync2_q;
    logic [NUM_IN-1:0] stable_q;
    logic [NUM_IN-1:0] stable_d;
    logic [CNT_W-1:0]  cnt_q [NUM_IN];
    logic [CNT_W-1:0]  cnt_d [NUM_IN];
    logic [NUM_IN-1:0] ev_q;
    logic [NUM_IN-1:0] ev_d;

    logic [1:0] pend_dir_q;
    logic [1:0] pend_dir_d;
    logic       pend_v_q;
    logic       pend_v_d;
    logic [1:0] dir_q;
    logic [1:0] dir_d;
    logic       have_dir_q;
    logic       have_dir_d;
    logic [3:0] push_q;
    logic [3:0] push_d;
    logic       pause_q;
    logic       pause_d;
    logic       valid_q;
    logic       valid_d;

    // Two-flop synchroniser for every raw input.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_act;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive cycles of disagreement, flip when the count is full.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DEB_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        ev_d = stable_d & ~stable_q;
    end

    // Debounce state and press-event registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stable_q <= '0;
            ev_q     <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            ev_q     <= ev_d;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    logic       pause_ev;
    logic       dir_ev_any;
    logic [1:0] ev_dir;
    logic       commit;
    logic       ref_valid;
    logic [1:0] ref_dir;
    logic       accept;

    // Pending request, commit and pause decisions.
    always_comb begin
        pause_ev   = ev_q[4];
        dir_ev_any = |ev_q[3:0];

        // Encoding UP=0, DOWN=1, LEFT=2, RIGHT=3 makes the opposite direction dir ^ 1.
        ev_dir = 2'd0;
        if (ev_q[0]) begin
            ev_dir = 2'd0;
        end else if (ev_q[1]) begin
            ev_dir = 2'd1;
        end else if (ev_q[2]) begin
            ev_dir = 2'd2;
        end else if (ev_q[3]) begin
            ev_dir = 2'd3;
        end

        // A pause event on the tick cycle wins over the commit.
        commit = i_Tick && pend_v_q && !pause_q && !pause_ev;

        ref_valid = commit || have_dir_q;
        ref_dir   = commit ? pend_dir_q : dir_q;

        accept = dir_ev_any && !pause_q &&
                 (!ref_valid || ((ev_dir != ref_dir) && (ev_dir != (ref_dir ^ 2'b01))));

        pend_dir_d = pend_dir_q;
        pend_v_d   = pend_v_q;
        dir_d      = dir_q;
        have_dir_d = have_dir_q;
        push_d     = push_q;
        valid_d    = commit;
        pause_d    = pause_q ^ pause_ev;

        if (commit) begin
            dir_d      = pend_dir_q;
            have_dir_d = 1'b1;
            push_d     = ~(4'b0001 << pend_dir_q);
            pend_v_d   = 1'b0;
        end
        if (accept) begin
            pend_dir_d = ev_dir;
            pend_v_d   = 1'b1;
        end
        if (pause_ev && !pause_q) begin
            pend_v_d = 1'b0;
        end
    end

    // Committed direction, pending slot and registered outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pend_dir_q <= 2'd0;
            pend_v_q   <= 1'b0;
            dir_q      <= 2'd0;
            have_dir_q <= 1'b0;
            push_q     <= 4'b1111;
            pause_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            pend_dir_q <= pend_dir_d;
            pend_v_q   <= pend_v_d;
            dir_q      <= dir_d;
            have_dir_q <= have_dir_d;
            push_q     <= push_d;
            pause_q    <= pause_d;
            valid_q    <= valid_d;
        end
    end

    assign o_Push  = push_q;
    assign o_Pause = pause_q;
    assign o_Valid = valid_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl with DEBOUNCE_CYCLES=8.
module tb_snake_input_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] i_Push_Raw;
    logic       i_Pause_Raw;
    logic       i_Tick;
    logic [3:0] o_Push;
    logic       o_Pause;
    logic       o_Valid;

    int checks   = 0;
    int failures = 0;

    snake_input_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .CNT_W(4)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .i_Push_Raw(i_Push_Raw),
        .i_Pause_Raw(i_Pause_Raw),
        .i_Tick(i_Tick),
        .o_Push(o_Push),
        .o_Pause(o_Pause),
        .o_Valid(o_Valid)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hold the given buttons (active-high mask, pause separately) long enough to debounce,
    // then release and let the release debounce settle.
    task automatic press(input logic [3:0] dirs, input logic p);
        @(negedge Clk);
        i_Push_Raw  = ~dirs;
        i_Pause_Raw = p;
        repeat (20) @(negedge Clk);
        i_Push_Raw  = 4'b1111;
        i_Pause_Raw = 1'b0;
        repeat (20) @(negedge Clk);
    endtask

    // One-cycle tick; checks the pulse on the sampling edge, the level after, and o_Push.
    task automatic tick_check(input string tag, input logic exp_valid, input logic [3:0] exp_push);
        @(negedge Clk);
        i_Tick = 1'b1;
        @(posedge Clk);
        #1;
        check_eq({tag, "_valid"}, 32'(o_Valid), 32'(exp_valid));
        check_eq({tag, "_push"}, 32'(o_Push), 32'(exp_push));
        @(negedge Clk);
        i_Tick = 1'b0;
        @(posedge Clk);
        #1;
        check_eq({tag, "_valid_end"}, 32'(o_Valid), 32'd0);
    endtask

    initial begin
        Rst         = 1'b0;
        i_Push_Raw  = 4'b1111;
        i_Pause_Raw = 1'b0;
        i_Tick      = 1'b0;

        // 1. reset with random inputs, then idle
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            i_Push_Raw  = 4'($urandom_range(0, 15));
            i_Pause_Raw = 1'($urandom_range(0, 1));
            i_Tick      = 1'($urandom_range(0, 1));
            if (i % 4 == 3) begin
                check_eq("rst_push", 32'(o_Push), 32'hF);
                check_eq("rst_pause", 32'(o_Pause), 32'd0);
                check_eq("rst_valid", 32'(o_Valid), 32'd0);
            end
        end
        @(negedge Clk);
        i_Push_Raw  = 4'b1111;
        i_Pause_Raw = 1'b0;
        i_Tick      = 1'b0;
        Rst         = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (i % 10 == 9) begin
                check_eq("idle_push", 32'(o_Push), 32'hF);
                check_eq("idle_pause", 32'(o_Pause), 32'd0);
                check_eq("idle_valid", 32'(o_Valid), 32'd0);
            end
        end

        // 3. short UP glitches are never accepted
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            i_Push_Raw = 4'b1110;
            repeat (5) @(negedge Clk);
            i_Push_Raw = 4'b1111;
            repeat (2) @(negedge Clk);
        end
        repeat (20) @(negedge Clk);
        tick_check("glitch", 1'b0, 4'b1111);

        // 2. basic press and commit
        press(4'b0001, 1'b0);
        tick_check("up_commit", 1'b1, 4'b1110);
        tick_check("up_again", 1'b0, 4'b1110);

        // 4. reversal rejection and last press wins
        press(4'b0010, 1'b0);
        tick_check("down_rev", 1'b0, 4'b1110);
        press(4'b0100, 1'b0);
        press(4'b1000, 1'b0);
        tick_check("right_last", 1'b1, 4'b0111);

        // 5. pause timing: raw sampled at edge 0, o_Pause rises at edge 11
        @(negedge Clk);
        i_Pause_Raw = 1'b1;
        repeat (11) @(posedge Clk);
        #1;
        check_eq("pause_early", 32'(o_Pause), 32'd0);
        @(posedge Clk);
        #1;
        check_eq("pause_on", 32'(o_Pause), 32'd1);
        @(negedge Clk);
        i_Pause_Raw = 1'b0;
        repeat (20) @(negedge Clk);
        press(4'b0001, 1'b0);
        tick_check("paused_tick", 1'b0, 4'b0111);
        press(4'b0000, 1'b1);
        check_eq("pause_off", 32'(o_Pause), 32'd0);
        tick_check("unpaused_tick", 1'b0, 4'b0111);

        // same-cycle UP and DOWN events: UP has priority
        press(4'b0011, 1'b0);
        tick_check("prio_up", 1'b1, 4'b1110);

        // 6a. pause event coincident with tick while RIGHT is pending
        press(4'b1000, 1'b0);
        @(negedge Clk);
        i_Pause_Raw = 1'b1;
        repeat (11) @(posedge Clk);
        #1;
        i_Tick = 1'b1;
        @(posedge Clk);
        #1;
        check_eq("coinc_pause", 32'(o_Pause), 32'd1);
        check_eq("coinc_valid", 32'(o_Valid), 32'd0);
        check_eq("coinc_push", 32'(o_Push), 32'hE);
        @(negedge Clk);
        i_Tick      = 1'b0;
        i_Pause_Raw = 1'b0;
        repeat (20) @(negedge Clk);
        press(4'b0000, 1'b1);
        check_eq("coinc_unpause", 32'(o_Pause), 32'd0);
        tick_check("coinc_cleared", 1'b0, 4'b1110);

        // 6b. reset mid-debounce with a pending request
        press(4'b0100, 1'b0);
        @(negedge Clk);
        i_Push_Raw = 4'b1101;
        repeat (5) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check_eq("midrst_push", 32'(o_Push), 32'hF);
        check_eq("midrst_pause", 32'(o_Pause), 32'd0);
        check_eq("midrst_valid", 32'(o_Valid), 32'd0);
        i_Push_Raw = 4'b1111;
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        repeat (30) @(negedge Clk);
        tick_check("midrst_tick", 1'b0, 4'b1111);
        press(4'b0010, 1'b0);
        tick_check("post_rst_down", 1'b1, 4'b1101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
